// File: rtl/disk_arb_pkg.sv
// rtl/disk_arb_pkg.sv - shared types and constants for the disk channel arbiter
//
// Contents:
//   arb_state_t       channel FSM states (IDLE, GRANT, RELEASE)
//   REQ_BIT_DEFAULT   drive status bit meaning "host transfer requested"
//   DONE_BIT_DEFAULT  host control bit the host raises when a transfer completes
//   DRV0 / DRV1       drive ids as carried on the owner output
package disk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_BIT_DEFAULT  = 0;
  localparam int DONE_BIT_DEFAULT = 31;

  localparam logic DRV0 = 1'b0;
  localparam logic DRV1 = 1'b1;

endpackage

// File: rtl/disk_arb_watchdog.sv
// rtl/disk_arb_watchdog.sv - inactivity watchdog counter with clear/enable and expiry flag
//
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_clr      clear the count (wins over i_en)
//   i_en       count one cycle of inactivity
//   o_expired  high in the cycle whose increment brings the count to all-ones,
//              so the owner can act on the same edge the count gets there
module disk_arb_watchdog #(
  parameter int TO_W = 20
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;
  logic [TO_W-1:0] w_count_inc;

  assign w_count_inc = r_count + 1'b1;
  assign o_expired   = i_en & ~i_clr & (&w_count_inc);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !(&r_count)) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/disk_channel_arbiter.sv
// rtl/disk_channel_arbiter.sv - round-robin arbiter sharing one host disk channel between two drives
//
// Optional feature macro: DISKARB_SELECT_FOLLOW_EN (owner follows chip-select falls while idle,
// with a read-only status preview of that drive).
//
// Ports:
//   clk24 / rstn                        clock, asynchronous active-low reset
//   host_cr, host_din                   control word and data byte from the ctrl-module
//   host_clkin, host_clkout             single-cycle host data strobes
//   host_sr, host_dout                  status word and data byte of the owning drive
//   drv_sr0/1, drv_dout0/1              status and data from each drive
//   drv_cr0/1, drv_din                  control word per drive, data byte to both drives
//   drv_clkin0/1, drv_clkout0/1         strobes gated to the owning drive only
//   cpu_sel_n                           disk1_n / disk2_n chip selects (optional feature only)
//   owner, grant_valid, timeout_err     arbitration status
module disk_channel_arbiter
  import disk_arb_pkg::*;
#(
  parameter int REQ_BIT      = REQ_BIT_DEFAULT,
  parameter int DONE_BIT     = DONE_BIT_DEFAULT,
  parameter int GUARD_CYCLES = 4,
  parameter int TO_W         = 20
) (
  input  logic        clk24,
  input  logic        rstn,
  input  logic [31:0] host_cr,
  output logic [31:0] host_sr,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  input  logic        host_clkin,
  input  logic        host_clkout,
  input  logic [31:0] drv_sr0,
  input  logic [31:0] drv_sr1,
  input  logic [7:0]  drv_dout0,
  input  logic [7:0]  drv_dout1,
  output logic [31:0] drv_cr0,
  output logic [31:0] drv_cr1,
  output logic [7:0]  drv_din,
  output logic        drv_clkin0,
  output logic        drv_clkin1,
  output logic        drv_clkout0,
  output logic        drv_clkout1,
  input  logic [1:0]  cpu_sel_n,
  output logic        owner,
  output logic        grant_valid,
  output logic        timeout_err
);

  localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [GW:0] GUARD_END = (GW + 1)'(GUARD_CYCLES);

  arb_state_t    r_state, w_state_nxt;
  logic          r_owner, r_rr_last, r_done_prev, r_timeout_err;
  logic [GW-1:0] r_guard;

  logic          w_req0, w_req1, w_owner_req, w_done_edge, w_strobe;
  logic          w_grant, w_grant_id, w_rel_timeout, w_wd_expired, w_guard_done;
  logic [31:0]   w_owner_sr;

  assign w_req0      = drv_sr0[REQ_BIT];
  assign w_req1      = drv_sr1[REQ_BIT];
  assign w_owner_req = r_owner ? w_req1 : w_req0;
  assign w_owner_sr  = r_owner ? drv_sr1 : drv_sr0;
  assign w_done_edge = host_cr[DONE_BIT] & ~r_done_prev;
  assign w_strobe    = host_clkin | host_clkout;
  // "count + 1 reaches GUARD_CYCLES" keeps GUARD_CYCLES=0 at a single RELEASE cycle
  assign w_guard_done = ({1'b0, r_guard} + {{GW{1'b0}}, 1'b1}) >= GUARD_END;

  // Held in clear outside GRANT, so every grant starts the watchdog from zero
  disk_arb_watchdog #(.TO_W(TO_W)) u_watchdog (
    .i_clk     (clk24),
    .i_rstn    (rstn),
    .i_clr     ((r_state != GRANT) | w_strobe),
    .i_en      (r_state == GRANT),
    .o_expired (w_wd_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_id    = DRV0;
    w_rel_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_grant     = 1'b1;
          // On a tie the drive that did not win last time goes next
          w_grant_id  = (w_req0 & w_req1) ? ~r_rr_last : w_req1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_done_edge || !w_owner_req) begin
          w_state_nxt = RELEASE;
        end else if (w_wd_expired) begin
          w_state_nxt   = RELEASE;
          w_rel_timeout = 1'b1;
        end
      end
      RELEASE: begin
        if (w_guard_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath is a pure function of the registered state, so an asserted rstn
  // blocks every strobe in the same cycle.
  always_comb begin
    host_sr     = '0;
    host_dout   = '0;
    drv_cr0     = '0;
    drv_cr1     = '0;
    drv_clkin0  = 1'b0;
    drv_clkin1  = 1'b0;
    drv_clkout0 = 1'b0;
    drv_clkout1 = 1'b0;
    if (r_state == GRANT) begin
      host_sr   = w_owner_sr;
      host_dout = r_owner ? drv_dout1 : drv_dout0;
      if (r_owner == DRV1) begin
        drv_cr1     = host_cr;
        drv_clkin1  = host_clkin;
        drv_clkout1 = host_clkout;
      end else begin
        drv_cr0     = host_cr;
        drv_clkin0  = host_clkin;
        drv_clkout0 = host_clkout;
      end
    end
`ifdef DISKARB_SELECT_FOLLOW_EN
    else if (r_state == IDLE) begin
      host_sr = w_owner_sr;
    end
`endif
  end

  assign drv_din     = host_din;
  assign owner       = r_owner;
  assign grant_valid = (r_state == GRANT);
  assign timeout_err = r_timeout_err;

`ifdef DISKARB_SELECT_FOLLOW_EN
  logic [1:0] r_sel_prev;
  logic [1:0] w_sel_fall;
  assign w_sel_fall = r_sel_prev & ~cpu_sel_n;

  always_ff @(posedge clk24 or negedge rstn) begin
    if (!rstn) r_sel_prev <= 2'b11;
    else       r_sel_prev <= cpu_sel_n;
  end
`else
  logic w_unused_sel;
  assign w_unused_sel = ^cpu_sel_n;
`endif

  always_ff @(posedge clk24 or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_owner       <= DRV0;
      r_rr_last     <= DRV1;
      r_done_prev   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_guard       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_prev <= host_cr[DONE_BIT];
      if (w_grant) begin
        r_owner       <= w_grant_id;
        r_rr_last     <= w_grant_id;
        r_timeout_err <= 1'b0;
      end else if (w_rel_timeout) begin
        r_timeout_err <= 1'b1;
      end
`ifdef DISKARB_SELECT_FOLLOW_EN
      // No grant in IDLE means no requests; simultaneous falls favour drive 1
      else if (r_state == IDLE && w_sel_fall != 2'b00) begin
        r_owner <= w_sel_fall[1] ? DRV1 : DRV0;
      end
`endif
      if (r_state == RELEASE) begin
        r_guard <= (&r_guard) ? r_guard : r_guard + 1'b1;
      end else begin
        r_guard <= '0;
      end
    end
  end

endmodule

// File: tb/tb_disk_channel_arbiter.sv
// tb/tb_disk_channel_arbiter.sv - self-checking bench for disk_channel_arbiter
module tb_disk_channel_arbiter;

  localparam int TO_W  = 4;
  localparam int GUARD = 4;

  logic        clk24 = 1'b0;
  logic        rstn;
  logic [31:0] host_cr, host_sr, drv_sr0, drv_sr1, drv_cr0, drv_cr1;
  logic [7:0]  host_din, host_dout, drv_dout0, drv_dout1, drv_din;
  logic        host_clkin, host_clkout;
  logic        drv_clkin0, drv_clkin1, drv_clkout0, drv_clkout1;
  logic [1:0]  cpu_sel_n;
  logic        owner, grant_valid, timeout_err;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  disk_channel_arbiter #(
    .REQ_BIT(0), .DONE_BIT(31), .GUARD_CYCLES(GUARD), .TO_W(TO_W)
  ) dut (
    .clk24(clk24), .rstn(rstn),
    .host_cr(host_cr), .host_sr(host_sr),
    .host_din(host_din), .host_dout(host_dout),
    .host_clkin(host_clkin), .host_clkout(host_clkout),
    .drv_sr0(drv_sr0), .drv_sr1(drv_sr1),
    .drv_dout0(drv_dout0), .drv_dout1(drv_dout1),
    .drv_cr0(drv_cr0), .drv_cr1(drv_cr1), .drv_din(drv_din),
    .drv_clkin0(drv_clkin0), .drv_clkin1(drv_clkin1),
    .drv_clkout0(drv_clkout0), .drv_clkout1(drv_clkout1),
    .cpu_sel_n(cpu_sel_n),
    .owner(owner), .grant_valid(grant_valid), .timeout_err(timeout_err)
  );

  always #5 clk24 = ~clk24;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (grant_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_grant: got %b want 0", grant_valid); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL rst_owner: got %b want 0", owner); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    total++; if (host_sr !== 32'h0 || host_dout !== 8'h0) begin bad++; $display("FAIL rst_host: sr=%h dout=%h want 0", host_sr, host_dout); end
    total++; if (drv_cr0 !== 32'h0 || drv_cr1 !== 32'h0) begin bad++; $display("FAIL rst_cr: cr0=%h cr1=%h want 0", drv_cr0, drv_cr1); end
    rstn = 1'b1;
    tick();
    // mid-GRANT reset with a strobe active
    drv_sr1 = 32'h0000_0001;
    tick();
    total++; if (grant_valid !== 1'b1 || owner !== 1'b1) begin bad++; $display("FAIL rstmid_grant: grant=%b owner=%b want 1 1", grant_valid, owner); end
    host_clkin = 1'b1;
    #1;
    total++; if (drv_clkin1 !== 1'b1) begin bad++; $display("FAIL rstmid_pre: drv_clkin1=%b want 1", drv_clkin1); end
    rstn = 1'b0;
    #1;
    total++; if (drv_clkin0 !== 1'b0 || drv_clkin1 !== 1'b0) begin bad++; $display("FAIL rstmid_leak: clkin0=%b clkin1=%b want 0 0", drv_clkin0, drv_clkin1); end
    total++; if (grant_valid !== 1'b0 || owner !== 1'b0 || host_sr !== 32'h0) begin bad++; $display("FAIL rstmid_out: grant=%b owner=%b sr=%h want 0", grant_valid, owner, host_sr); end
    tick();
    host_clkin = 1'b0;
    drv_sr1    = 32'h0;
    rstn       = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit   ok;
    logic e;
    drv_sr0   = 32'h1234_5670;
    drv_sr1   = 32'hA5A5_0001;
    drv_dout1 = 8'h3C;
    drv_dout0 = 8'hC3;
    host_cr   = 32'h0000_00F0;
    tick();
    total++; if (grant_valid !== 1'b1 || owner !== 1'b1) begin bad++; $display("FAIL single_grant: grant=%b owner=%b want 1 1", grant_valid, owner); end
    total++; if (host_sr !== 32'hA5A5_0001 || host_dout !== 8'h3C) begin bad++; $display("FAIL single_mux: sr=%h dout=%h want a5a50001 3c", host_sr, host_dout); end
    total++; if (drv_cr1 !== 32'h0000_00F0 || drv_cr0 !== 32'h0) begin bad++; $display("FAIL single_cr: cr1=%h cr0=%h want f0 0", drv_cr1, drv_cr0); end
    for (int i = 0; i < 512; i++) begin
      host_din   = 8'(i);
      host_clkin = 1'b1;
      exp_q.push_back(1'b1);
      #1;
      if (drv_clkin0 === 1'b1 || drv_clkin1 === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if (drv_clkin1 !== e || drv_clkin0 !== ~e) begin
          bad++; $display("FAIL single_strobe %0d: clkin1=%b clkin0=%b want drive %0d", i, drv_clkin1, drv_clkin0, e);
        end
      end
      total++; if (drv_din !== 8'(i)) begin bad++; $display("FAIL single_din %0d: got %h want %h", i, drv_din, 8'(i)); end
      tick();
      host_clkin = 1'b0;
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing: %0d strobes not seen, want 0", exp_q.size()); end
    exp_q.delete();
    host_clkout = 1'b1;
    #1;
    total++; if (drv_clkout1 !== 1'b1 || drv_clkout0 !== 1'b0) begin bad++; $display("FAIL single_clkout: out1=%b out0=%b want 1 0", drv_clkout1, drv_clkout0); end
    tick();
    host_clkout = 1'b0;
    total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL single_hold: grant=%b want 1", grant_valid); end
  endtask

  task automatic test_abandon_1();
    drv_sr1 = 32'hA5A5_0000;
    tick();
    total++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0 || owner !== 1'b1) begin bad++; $display("FAIL abandon1: grant=%b terr=%b owner=%b want 0 0 1", grant_valid, timeout_err, owner); end
    host_clkin = 1'b1;
    #1;
    total++; if (drv_clkin1 !== 1'b0) begin bad++; $display("FAIL abandon1_gate: clkin1=%b want 0", drv_clkin1); end
    host_clkin = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_tie();
    bit   ok;
    logic e;
    host_cr = 32'h0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    drv_sr0 = 32'h0000_0001;
    drv_sr1 = 32'h0000_0001;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int r = 0; r < 4; r++) begin
      wait_grant(20, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL tie_round%0d: no grant within 20 cycles, want drive %0d", r, e); end
      else if (owner !== e) begin bad++; $display("FAIL tie_round%0d: owner=%b want %0d", r, owner, e); end
      host_cr = 32'h8000_0000;
      tick();
      host_cr = 32'h0;
    end
    drv_sr0 = 32'h0;
    drv_sr1 = 32'h0;
    repeat (8) tick();
  endtask

  task automatic test_done_guard();
    bit ok;
    int cnt;
    drv_sr0   = 32'h0000_0011;
    drv_dout0 = 8'h5A;
    tick();
    wait_grant(10, ok);
    total++; if (!ok || owner !== 1'b0 || host_dout !== 8'h5A) begin bad++; $display("FAIL done_grant: ok=%b owner=%b dout=%h want 1 0 5a", ok, owner, host_dout); end
    host_cr    = 32'h8000_0000;
    host_clkin = 1'b1;
    #1;
    total++; if (drv_clkin0 !== 1'b1) begin bad++; $display("FAIL done_same_cycle: clkin0=%b want 1", drv_clkin0); end
    tick();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (grant_valid === 1'b1) break;
      cnt++;
      total++; if (drv_clkin0 !== 1'b0 || drv_clkin1 !== 1'b0) begin bad++; $display("FAIL done_gated %0d: clkin0=%b clkin1=%b want 0 0", k, drv_clkin0, drv_clkin1); end
      tick();
    end
    // GUARD cycles in RELEASE, then one IDLE cycle sampling the request
    total++; if (cnt != GUARD + 1) begin bad++; $display("FAIL done_gap: %0d ungranted cycles, want %0d", cnt, GUARD + 1); end
    host_clkin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL done_level %0d: grant=%b want 1", k, grant_valid); end
    end
    host_cr = 32'h0;
  endtask

  task automatic test_abandon_0();
    drv_sr0 = 32'h0000_0010;
    tick();
    total++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL abandon0: grant=%b terr=%b owner=%b want 0 0 0", grant_valid, timeout_err, owner); end
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    drv_sr1 = 32'h0000_0001;
    wait_grant(10, ok);
    total++; if (!ok || owner !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_grant: ok=%b owner=%b terr=%b want 1 1 0", ok, owner, timeout_err); end
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (grant_valid !== 1'b1) break;
      cnt++;
      tick();
    end
    total++; if (cnt != (1 << TO_W) - 1) begin bad++; $display("FAIL to_cycles: granted %0d cycles, want %0d", cnt, (1 << TO_W) - 1); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag: terr=%b want 1", timeout_err); end
    wait_grant(20, ok);
    total++; if (!ok || timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: ok=%b terr=%b want 1 0", ok, timeout_err); end
    drv_sr1 = 32'h0;
    repeat (8) tick();
  endtask

`ifdef DISKARB_SELECT_FOLLOW_EN
  task automatic test_select();
    drv_sr0   = 32'h0000_0E00;
    drv_sr1   = 32'h0000_0B00;
    cpu_sel_n = 2'b01;
    tick();
    host_clkin = 1'b1;
    host_cr    = 32'h0000_0077;
    #1;
    total++; if (owner !== 1'b1 || host_sr !== 32'h0000_0B00) begin bad++; $display("FAIL sel_follow: owner=%b sr=%h want 1 b00", owner, host_sr); end
    total++; if (drv_cr1 !== 32'h0 || drv_clkin1 !== 1'b0 || grant_valid !== 1'b0) begin bad++; $display("FAIL sel_blocked: cr1=%h clkin1=%b grant=%b want 0", drv_cr1, drv_clkin1, grant_valid); end
    host_clkin = 1'b0;
    host_cr    = 32'h0;
    cpu_sel_n  = 2'b11;
    tick();
  endtask
`endif

  initial begin
    rstn = 1'b0; host_cr = '0; host_din = '0; host_clkin = 1'b0; host_clkout = 1'b0;
    drv_sr0 = '0; drv_sr1 = '0; drv_dout0 = '0; drv_dout1 = '0; cpu_sel_n = 2'b11;
    test_reset();
    test_single();
    test_abandon_1();
    test_tie();
    test_done_guard();
    test_abandon_0();
    test_timeout();
`ifdef DISKARB_SELECT_FOLLOW_EN
    test_select();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
